// File: rtl/commit_trace_pkg.sv
// Shared types and constants for the commit trace buffer.
// An entry is one architectural commit: a register write or a store.
package commit_trace_pkg;

    localparam logic [1:0] TR_REG     = 2'b01;
    localparam logic [1:0] TR_MEM     = 2'b10;
    localparam int         DROP_CNT_W = 16;
    localparam int         ENTRY_W    = 103;

    typedef struct packed {
        logic [1:0]  typ;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] cycle;
    } trace_entry_t;

endpackage

// File: rtl/trace_fifo2w.sv
// Dual-push, single-pop synchronous FIFO with first-word fall-through head.
// Lane 0 is written ahead of lane 1 when both push; the caller guarantees room.
module trace_fifo2w #(
    parameter int DEPTH = 16,
    parameter int W     = 103
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   push0_i,
    input  logic [W-1:0]           push0_data_i,
    input  logic                   push1_i,
    input  logic [W-1:0]           push1_data_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_data_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic [$clog2(DEPTH):0] free_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr1_ptr;
    logic [CW-1:0] count_q, count_d;
    logic          pop_ok;

    always_comb begin
        pop_ok   = pop_i && (count_q != '0);
        // Lane 1 lands right after lane 0 only if lane 0 actually pushed.
        wr1_ptr  = wr_ptr_q + PW'(push0_i);
        wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_ok);
        count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_ok);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            if (push0_i) mem_q[wr_ptr_q] <= push0_data_i;
            if (push1_i) mem_q[wr1_ptr]  <= push1_data_i;
        end
    end

    assign head_data_o = mem_q[rd_ptr_q];
    assign count_o     = count_q;
    assign free_o      = CW'(DEPTH) - count_q;

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures WB register writes and MEM stores as timestamped trace entries,
// queues them for a valid/ready consumer and accounts for any dropped events.
module commit_trace_buffer
    import commit_trace_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter bit LOG_R0 = 1'b0
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   wb_regwrite_i,
    input  logic [4:0]             wb_rd_i,
    input  logic [31:0]            wb_data_i,
    input  logic [31:0]            wb_pc_i,
    input  logic                   mem_write_i,
    input  logic [31:0]            mem_addr_i,
    input  logic [31:0]            mem_wdata_i,
    output logic                   tr_valid_o,
    input  logic                   tr_ready_i,
    output logic [1:0]             tr_type_o,
    output logic [4:0]             tr_rd_o,
    output logic [31:0]            tr_addr_o,
    output logic [31:0]            tr_data_o,
    output logic [31:0]            tr_cycle_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   overflow_o,
    output logic [15:0]            drop_cnt_o
);

    localparam int CW  = $clog2(DEPTH) + 1;
    localparam int DSW = DROP_CNT_W + 1;

    logic [31:0]           cycle_q, cycle_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [DSW-1:0]        drop_sum;
    logic                  reg_ev, mem_ev, push_reg, push_mem;
    logic [1:0]            n_drop;
    logic [CW-1:0]         free;
    logic [CW-1:0]         count;
    trace_entry_t          reg_entry, mem_entry, head, shown;

    always_comb begin
        reg_ev    = wb_regwrite_i && ((wb_rd_i != 5'd0) || LOG_R0);
        mem_ev    = mem_write_i;
        // Room is judged on start-of-cycle occupancy; REG has priority over MEM.
        push_reg  = reg_ev && (free != '0);
        push_mem  = mem_ev && (free > CW'(push_reg));
        n_drop    = 2'(reg_ev && !push_reg) + 2'(mem_ev && !push_mem);
        drop_sum  = {1'b0, drop_cnt_q} + DSW'(n_drop);

        cycle_d    = cycle_q + 32'd1;
        overflow_d = overflow_q || (n_drop != 2'd0);
        drop_cnt_d = drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];

        reg_entry = '{typ: TR_REG, rd: wb_rd_i, addr: wb_pc_i,
                      data: wb_data_i, cycle: cycle_q};
        mem_entry = '{typ: TR_MEM, rd: 5'd0, addr: mem_addr_i,
                      data: mem_wdata_i, cycle: cycle_q};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cycle_q    <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            cycle_q    <= cycle_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    trace_fifo2w #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .push0_i      (push_reg),
        .push0_data_i (reg_entry),
        .push1_i      (push_mem),
        .push1_data_i (mem_entry),
        .pop_i        (tr_ready_i),
        .head_data_o  (head),
        .count_o      (count),
        .free_o       (free)
    );

    // Storage is uninitialised after reset, so the head is masked while empty.
    assign tr_valid_o = (count != '0);
    assign shown      = tr_valid_o ? head : '0;
    assign tr_type_o  = shown.typ;
    assign tr_rd_o    = shown.rd;
    assign tr_addr_o  = shown.addr;
    assign tr_data_o  = shown.data;
    assign tr_cycle_o = shown.cycle;
    assign count_o    = count;
    assign overflow_o = overflow_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed bench for commit_trace_buffer: one instance filters r0 writes,
// a second identical-stimulus instance logs them.
module tb_commit_trace_buffer;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        wb_regwrite_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i, wb_pc_i;
    logic        mem_write_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic        tr_ready_i;

    logic        tr_valid_o, r0_valid;
    logic [1:0]  tr_type_o, r0_type;
    logic [4:0]  tr_rd_o, r0_rd;
    logic [31:0] tr_addr_o, tr_data_o, tr_cycle_o;
    logic [31:0] r0_addr, r0_data, r0_cycle;
    logic [4:0]  count_o, r0_count;
    logic        overflow_o, r0_overflow;
    logic [15:0] drop_cnt_o, r0_drop;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    commit_trace_buffer #(.DEPTH(16), .LOG_R0(1'b0)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .wb_pc_i(wb_pc_i),
        .mem_write_i(mem_write_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .tr_valid_o(tr_valid_o), .tr_ready_i(tr_ready_i), .tr_type_o(tr_type_o), .tr_rd_o(tr_rd_o),
        .tr_addr_o(tr_addr_o), .tr_data_o(tr_data_o), .tr_cycle_o(tr_cycle_o),
        .count_o(count_o), .overflow_o(overflow_o), .drop_cnt_o(drop_cnt_o)
    );

    commit_trace_buffer #(.DEPTH(16), .LOG_R0(1'b1)) dut_r0 (
        .clk_i(clk), .rst_i(rst_i),
        .wb_regwrite_i(wb_regwrite_i), .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .wb_pc_i(wb_pc_i),
        .mem_write_i(mem_write_i), .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
        .tr_valid_o(r0_valid), .tr_ready_i(tr_ready_i), .tr_type_o(r0_type), .tr_rd_o(r0_rd),
        .tr_addr_o(r0_addr), .tr_data_o(r0_data), .tr_cycle_o(r0_cycle),
        .count_o(r0_count), .overflow_o(r0_overflow), .drop_cnt_o(r0_drop)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wb_regwrite_i = 1'b0;
        wb_rd_i       = 'x;
        wb_data_i     = 'x;
        wb_pc_i       = 'x;
        mem_write_i   = 1'b0;
        mem_addr_i    = 'x;
        mem_wdata_i   = 'x;
    endtask

    task automatic drive_reg(input logic [4:0] rd, input logic [31:0] data, input logic [31:0] pc);
        wb_regwrite_i = 1'b1;
        wb_rd_i       = rd;
        wb_data_i     = data;
        wb_pc_i       = pc;
    endtask

    task automatic drive_mem(input logic [31:0] addr, input logic [31:0] data);
        mem_write_i = 1'b1;
        mem_addr_i  = addr;
        mem_wdata_i = data;
    endtask

    task automatic test_reset();
        rst_i = 1'b0; tr_ready_i = 1'b0; idle_inputs();
        tick();
        checks++; if (tr_valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", tr_valid_o); else passes++;
        checks++; if (count_o !== 5'd0) $display("FAIL reset_count: got %0d want 0", count_o); else passes++;
        checks++; if ({overflow_o, drop_cnt_o} !== 17'd0) $display("FAIL reset_ovf_drop: got %b/%0d want 0/0", overflow_o, drop_cnt_o); else passes++;
        checks++; if ({tr_type_o, tr_data_o, tr_cycle_o} !== '0) $display("FAIL reset_data: got type %b data %h cyc %h want 0", tr_type_o, tr_data_o, tr_cycle_o); else passes++;
        rst_i = 1'b1;
        repeat (10) tick();
        checks++; if ({tr_valid_o, count_o, overflow_o, drop_cnt_o} !== '0) $display("FAIL idle_state: got v%b c%0d o%b d%0d want all 0", tr_valid_o, count_o, overflow_o, drop_cnt_o); else passes++;
    endtask

    task automatic test_single();
        tr_ready_i = 1'b1;
        drive_reg(5'd5, 32'h1234, 32'h40);
        tick();
        idle_inputs();
        checks++; if ({tr_valid_o, tr_type_o, tr_rd_o} !== {1'b1, 2'b01, 5'd5}) $display("FAIL single_hdr: got v%b t%b rd%0d want v1 t01 rd5", tr_valid_o, tr_type_o, tr_rd_o); else passes++;
        checks++; if ({tr_addr_o, tr_data_o} !== {32'h40, 32'h1234}) $display("FAIL single_payload: got %h/%h want 40/1234", tr_addr_o, tr_data_o); else passes++;
        checks++; if (tr_cycle_o !== 32'd10) $display("FAIL single_stamp: got %0d want 10", tr_cycle_o); else passes++;
        tick();
        checks++; if ({tr_valid_o, count_o} !== 6'd0) $display("FAIL single_popped: got v%b c%0d want v0 c0", tr_valid_o, count_o); else passes++;
        tr_ready_i = 1'b0;
    endtask

    task automatic test_dual();
        // Empty until now, 12 edges since reset: stamp is 12.
        drive_reg(5'd3, 32'd7, 32'h100);
        drive_mem(32'h8, 32'd9);
        tick();
        idle_inputs();
        checks++; if (count_o !== 5'd2) $display("FAIL dual_count: got %0d want 2", count_o); else passes++;
        checks++; if ({tr_type_o, tr_rd_o, tr_addr_o, tr_data_o} !== {2'b01, 5'd3, 32'h100, 32'd7}) $display("FAIL dual_head_reg: got t%b rd%0d a%h d%h", tr_type_o, tr_rd_o, tr_addr_o, tr_data_o); else passes++;
        checks++; if (tr_cycle_o !== 32'd12) $display("FAIL dual_stamp_reg: got %0d want 12", tr_cycle_o); else passes++;
        tr_ready_i = 1'b1;
        tick();
        tr_ready_i = 1'b0;
        checks++; if (count_o !== 5'd1) $display("FAIL dual_count_after_pop: got %0d want 1", count_o); else passes++;
        checks++; if ({tr_type_o, tr_rd_o, tr_addr_o, tr_data_o} !== {2'b10, 5'd0, 32'h8, 32'd9}) $display("FAIL dual_head_mem: got t%b rd%0d a%h d%h", tr_type_o, tr_rd_o, tr_addr_o, tr_data_o); else passes++;
        checks++; if (tr_cycle_o !== 32'd12) $display("FAIL dual_stamp_mem: got %0d want 12", tr_cycle_o); else passes++;
        tick();
        checks++; if ({count_o, tr_data_o} !== {5'd1, 32'd9}) $display("FAIL dual_stall_stable: got c%0d d%h want c1 d9", count_o, tr_data_o); else passes++;
        tr_ready_i = 1'b1;
        tick();
        tr_ready_i = 1'b0;
        checks++; if (count_o !== 5'd0) $display("FAIL dual_drained: got %0d want 0", count_o); else passes++;
    endtask

    task automatic test_r0();
        drive_reg(5'd0, 32'hAA, 32'h200);
        tick();
        idle_inputs();
        checks++; if (count_o !== 5'd0) $display("FAIL r0_filtered: got %0d want 0", count_o); else passes++;
        checks++; if (r0_count !== 5'd1) $display("FAIL r0_logged_count: got %0d want 1", r0_count); else passes++;
        checks++; if ({r0_type, r0_rd, r0_data} !== {2'b01, 5'd0, 32'hAA}) $display("FAIL r0_logged_entry: got t%b rd%0d d%h want t01 rd0 dAA", r0_type, r0_rd, r0_data); else passes++;
        tr_ready_i = 1'b1;
        tick();
        tr_ready_i = 1'b0;
        checks++; if (r0_count !== 5'd0) $display("FAIL r0_drained: got %0d want 0", r0_count); else passes++;
    endtask

    task automatic test_overflow();
        for (int i = 1; i <= 17; i++) begin
            drive_reg(5'(i), 32'(i), 32'(4 * i));
            tick();
        end
        idle_inputs();
        checks++; if (count_o !== 5'd16) $display("FAIL ovf_count_full: got %0d want 16", count_o); else passes++;
        checks++; if ({overflow_o, drop_cnt_o} !== {1'b1, 16'd1}) $display("FAIL ovf_first_drop: got o%b d%0d want o1 d1", overflow_o, drop_cnt_o); else passes++;
        checks++; if (tr_rd_o !== 5'd1) $display("FAIL ovf_head_oldest: got rd%0d want rd1", tr_rd_o); else passes++;
        tr_ready_i = 1'b1;
        tick();
        tr_ready_i = 1'b0;
        checks++; if ({count_o, tr_rd_o} !== {5'd15, 5'd2}) $display("FAIL ovf_one_pop: got c%0d rd%0d want c15 rd2", count_o, tr_rd_o); else passes++;
        drive_reg(5'd20, 32'd20, 32'h50);
        drive_mem(32'h100, 32'h55);
        tick();
        idle_inputs();
        checks++; if ({count_o, drop_cnt_o} !== {5'd16, 16'd2}) $display("FAIL ovf_reg_kept_mem_dropped: got c%0d d%0d want c16 d2", count_o, drop_cnt_o); else passes++;
        // Full with a simultaneous pop: the pop frees no room this cycle.
        tr_ready_i = 1'b1;
        drive_reg(5'd21, 32'd21, 32'h54);
        tick();
        idle_inputs();
        tr_ready_i = 1'b0;
        checks++; if ({count_o, drop_cnt_o} !== {5'd15, 16'd3}) $display("FAIL ovf_pop_no_room: got c%0d d%0d want c15 d3", count_o, drop_cnt_o); else passes++;
        tr_ready_i = 1'b1;
        repeat (14) tick();
        tr_ready_i = 1'b0;
        checks++; if ({count_o, tr_type_o, tr_rd_o, tr_data_o} !== {5'd1, 2'b01, 5'd20, 32'd20}) $display("FAIL ovf_last_entry: got c%0d t%b rd%0d d%h want c1 t01 rd20 d14", count_o, tr_type_o, tr_rd_o, tr_data_o); else passes++;
        tr_ready_i = 1'b1;
        tick();
        tr_ready_i = 1'b0;
        checks++; if ({count_o, overflow_o} !== {5'd0, 1'b1}) $display("FAIL ovf_sticky: got c%0d o%b want c0 o1", count_o, overflow_o); else passes++;
    endtask

    task automatic test_reset_mid_drain();
        for (int i = 1; i <= 8; i++) begin
            drive_reg(5'(i), 32'(i), 32'h0);
            tick();
        end
        idle_inputs();
        checks++; if (count_o !== 5'd8) $display("FAIL mid_fill: got %0d want 8", count_o); else passes++;
        tr_ready_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive_reg(5'd12, 32'h12, 32'h12);
        drive_mem(32'h20, 32'h21);
        tick();
        idle_inputs();
        tr_ready_i = 1'b0;
        checks++; if ({tr_valid_o, count_o, overflow_o, drop_cnt_o} !== '0) $display("FAIL mid_reset_clear: got v%b c%0d o%b d%0d want all 0", tr_valid_o, count_o, overflow_o, drop_cnt_o); else passes++;
        rst_i = 1'b1;
        drive_reg(5'd9, 32'h99, 32'h300);
        tick();
        idle_inputs();
        checks++; if ({count_o, tr_rd_o, tr_data_o} !== {5'd1, 5'd9, 32'h99}) $display("FAIL mid_new_entry: got c%0d rd%0d d%h want c1 rd9 d99", count_o, tr_rd_o, tr_data_o); else passes++;
        checks++; if (tr_cycle_o !== 32'd0) $display("FAIL mid_new_stamp: got %0d want 0", tr_cycle_o); else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_dual();
        test_r0();
        test_overflow();
        test_reset_mid_drain();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Sits downstream of the Pipe_CPU_1 writeback and memory stages.
- Captures every architectural commit: register-file writes from WB and data-memory stores from MEM.
- Each commit is timestamped and queued in a FIFO. The bench or host drains the FIFO through a valid/ready port, so it does not have to poll the whole register and memory state every cycle.
- Reports overflow and a drop count, so trace loss is always visible.

Parameters:
- DEPTH, 16, number of FIFO entries; power of two, 4..256.
- LOG_R0, 0, 1 = log writes targeting r0; 0 = filter them out.

Ports:
- clk_i  in  1  system clock, rising-edge.
- rst_i  in  1  synchronous, active-low reset (0 = reset, sampled on clk_i).
- wb_regwrite_i  in  1  WB stage commits a register write this cycle.
- wb_rd_i  in  5  destination register.
- wb_data_i  in  32  value written.
- wb_pc_i  in  32  PC of the committing instruction.
- mem_write_i  in  1  MEM stage commits a store this cycle.
- mem_addr_i  in  32  store byte address.
- mem_wdata_i  in  32  store data.
- tr_valid_o  out  1  head entry available.
- tr_ready_i  in  1  consumer accepts head entry.
- tr_type_o  out  2  entry type: 01 = REG, 10 = MEM.
- tr_rd_o  out  5  REG: rd; MEM: 0.
- tr_addr_o  out  32  REG: PC; MEM: store address.
- tr_data_o  out  32  value written.
- tr_cycle_o  out  32  cycle stamp of the commit.
- count_o  out  $clog2(DEPTH)+1  current occupancy.
- overflow_o  out  1  sticky: at least one event was dropped.
- drop_cnt_o  out  16  number of dropped events, saturating.

Behaviour:
- Reset (rst_i=0 at a rising edge):
  - Pointers, count_o, cycle counter, overflow_o and drop_cnt_o all go to 0.
  - tr_valid_o = 0. tr_* data outputs = 0.
  - Storage contents are don't-care.
  - A reset mid-drain discards all entries. Inputs are ignored during the reset cycle.
- Cycle counter: 32-bit, increments every non-reset cycle, wraps at 2^32-1 to 0. An entry is stamped with the counter value of its capture cycle.
- Event qualification:
  - REG event = wb_regwrite_i && (wb_rd_i != 0 || LOG_R0).
  - MEM event = mem_write_i.
- Capture ordering: both events may fire in one cycle. The REG entry is enqueued first, then the MEM entry, so 0, 1 or 2 pushes happen per cycle.
- Free space is computed from the occupancy at the start of the cycle. A pop in the same cycle does not create room for that cycle's pushes.
- Space rules:
  - Free space 0: every event in the cycle is dropped.
  - Free space 1 with two events: REG is enqueued, MEM is dropped.
  - Each dropped event sets overflow_o and increments drop_cnt_o (by 1 or 2 per cycle, saturating at 16'hFFFF).
  - overflow_o clears only on reset.
- Output handshake:
  - tr_valid_o = (count != 0).
  - The tr_* outputs present the head entry combinationally from storage: first-word fall-through, zero extra latency.
  - A pop occurs when tr_valid_o && tr_ready_i. The head then advances on that edge.
  - tr_* outputs stay stable while tr_valid_o=1 and tr_ready_i=0.
  - tr_ready_i while empty has no effect.
- Latency: an event captured at edge N becomes visible on tr_* after edge N when the FIFO was empty.
- Occupancy: count_next = count + pushes - pop, always within 0..DEPTH.
- Pointers are $clog2(DEPTH) bits and wrap naturally modulo DEPTH.
- Unknown or X inputs while the corresponding enable is 0 are ignored.

Decomposition:
- Package commit_trace_pkg holds:
  - the TR_REG = 2'b01 and TR_MEM = 2'b10 constants;
  - the 103-bit packed entry layout {type, rd, addr, data, cycle};
  - the DROP_CNT_W = 16 constant.
- Sub-module trace_fifo2w: a dual-push, single-pop synchronous FIFO with parameter DEPTH. It takes push0/push1 data, reports free space, and provides FWFT head data.
- The top level contains event qualification, the cycle counter, drop accounting and entry packing.

Test Plan:
- Reset then idle 10 cycles -> tr_valid_o=0, count_o=0, overflow_o=0, drop_cnt_o=0. The cycle stamp of the first later event is 10 when injected right after those 10 idle cycles.
- Single REG commit (rd=5, data=32'h1234, pc=32'h40), tr_ready_i=1 -> next cycle tr_valid_o=1, tr_type_o=01, tr_rd_o=5, tr_addr_o=32'h40, tr_data_o=32'h1234. Popped in 1 cycle, count returns to 0.
- Same-cycle REG (rd=3, data=7) and MEM (addr=32'h8, data=9), tr_ready_i=0 -> count_o=2. Head is REG; after one pop the head is MEM with addr 8, data 9. The two cycle stamps are equal.
- r0 write with LOG_R0=0 -> no entry, count_o unchanged. With LOG_R0=1 -> entry with tr_rd_o=0.
- DEPTH=16, tr_ready_i=0, 17 REG events -> count_o=16, overflow_o=1, drop_cnt_o=1. Then REG+MEM with count=15 -> REG kept, MEM dropped, drop_cnt_o=2.
- Fill to 8 entries, assert rst_i=0 for one cycle during a drain -> tr_valid_o=0, count_o=0, overflow_o=0 next cycle. A new event afterwards is stamped with cycle 0.
